status_frame_tx: RTL

STATUS_FRAME_TX -- requirements
Module: status_frame_tx

---
 rtl/status_frame_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/status_frame_tx.sv
// -----------------------------------------------------------------------------
// status_frame_tx
//
// Serialises a parallel device-status word into the following frame:
//   start bit (0), WIDTH data bits sent LSB first, even-parity bit, stop bit (1).
// Each bit is held on sdo for CLKS_PER_BIT clock cycles, so a frame lasts
// (WIDTH+3)*CLKS_PER_BIT cycles. After every frame there is one IDLE cycle in
// which done pulses. A load presented in that cycle starts the next frame, so
// frames can be sent back to back.
//
// Parameters
//   WIDTH         data bits per frame (1..16)
//   CLKS_PER_BIT  clock cycles per serial bit (1..255)
//
// Ports
//   clk    in   clock; all state changes happen on posedge
//   arst   in   synchronous active-high reset
//   din    in   [WIDTH]  status word, captured when load=1 and ready=1
//   load   in   transmit request
//   ready  out  block is idle and accepts load
//   sdo    out  registered serial data; idles at 1
//   busy   out  frame in progress (always the inverse of ready)
//   done   out  one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module status_frame_tx #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             sdo,
   output logic             busy,
   output logic             done
);

   // The bit-cycle counter counts 0..CLKS_PER_BIT-1. It is sized to hold
   // CLKS_PER_BIT itself, so it can never wrap inside a bit period.
   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned IW = $clog2(WIDTH + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             par_q, par_d;
   logic             sdo_q, sdo_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] shifted;
   logic             bit_end;

   // NOTE: every signal written in this block gets a default first. A path
   // that leaves a signal unassigned would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      sdo_d   = sdo_q;
      done_d  = 1'b0;
      shifted = shreg_q >> 1;
      bit_end = (cnt_q == CNT_LAST);

      // The counter runs in every non-idle state and restarts at each bit boundary.
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CW'(1);
      end

      // sdo is registered, so each transition loads the value of the bit that
      // the next state will present.
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = START;
               shreg_d = din;
               par_d   = ^din;   // even parity over the captured word
               idx_d   = '0;
               cnt_d   = '0;
               sdo_d   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               sdo_d   = shreg_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shifted;
               if (idx_q == IDX_LAST) begin
                  state_d = PARITY;
                  sdo_d   = par_q;
               end else begin
                  idx_d = idx_q + IW'(1);
                  sdo_d = shifted[0];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               sdo_d   = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               sdo_d   = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            sdo_d   = 1'b1;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments. Every register then
   // samples pre-edge values, whatever order the statements are written in.
   always_ff @(posedge clk) begin
      if (arst) begin
         // The shift register is cleared as well. An aborted frame then leaves
         // no stale data behind it.
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         sdo_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         sdo_q   <= sdo_d;
         done_q  <= done_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign busy  = ~ready;
   assign sdo   = sdo_q;
   assign done  = done_q;

endmodule
